// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with negative sync pulses.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam bit DEF_HS_POL    = 1'b0;
    localparam bit DEF_VS_POL    = 1'b0;

    // Pixels per line, sync through front porch.
    function automatic int h_total(input int sync_w, input int back_w,
                                   input int visible_w, input int front_w);
        return sync_w + back_w + visible_w + front_w;
    endfunction

    // Lines per frame, sync through front porch.
    function automatic int v_total(input int sync_w, input int back_w,
                                   input int visible_w, input int front_w);
        return sync_w + back_w + visible_w + front_w;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Output bundle of the VGA timing generator: raster strobes, coordinates
// and DAC pins. The generator drives the master side.
interface vga_timing_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          hsync;
    logic          vsync;
    logic          display_area;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          pix_en;
    logic          line_start;
    logic          frame_start;
    logic          vga_blank_n;
    logic          vga_sync_n;
    logic          vga_clk;

    modport master (
        output hsync, vsync, display_area, x, y, pix_en,
               line_start, frame_start, vga_blank_n, vga_sync_n, vga_clk
    );

    modport slave (
        input  hsync, vsync, display_area, x, y, pix_en,
               line_start, frame_start, vga_blank_n, vga_sync_n, vga_clk
    );
endinterface

// File: rtl/pix_clk_div.sv
// Pixel-enable divider: div_cnt runs 0..CLK_DIV-1. adv is the combinational
// look-ahead (pix_en for the next cycle) so the raster counters can step on
// the same edge that raises the registered pix_en.
module pix_clk_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic adv,
    output logic pix_en,
    output logic vga_clk
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_cnt_r;
    logic [DW-1:0] div_next_s;
    logic          pix_en_r;
    logic          vga_clk_r;

    // Next divider count with wrap, and the advance look-ahead.
    always_comb begin
        div_next_s = div_cnt_r;
        if (div_cnt_r == DIV_LAST) begin
            div_next_s = '0;
        end else begin
            div_next_s = div_cnt_r + DW'(1);
        end
        adv = (div_next_s == DIV_LAST);
    end

    // Divider state plus registered pixel strobe and DAC clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            pix_en_r  <= 1'b0;
            vga_clk_r <= 1'b0;
        end else begin
            div_cnt_r <= div_next_s;
            pix_en_r  <= adv;
            vga_clk_r <= (div_next_s >= DIV_HALF);
        end
    end

    assign pix_en  = pix_en_r;
    assign vga_clk = vga_clk_r;
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (sync, back porch, visible,
// front porch). All outputs are registered from the next counter values.
// Optional macro VGA_TIMING_LEAD_EN: x, y and display_area describe the
// following pixel so a one-cycle sprite ROM lines up; vga_blank_n stays aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit HS_POL    = DEF_HS_POL,
    parameter bit VS_POL    = DEF_VS_POL
) (
    input  logic         clk50,
    input  logic         rst_n,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_VISIBLE, H_FRONT);
    localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_VISIBLE, V_FRONT);
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(H_VISIBLE);
    localparam int YW = $clog2(V_VISIBLE);

    localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_START_C = HW'(H_START);
    localparam logic [HW-1:0] H_END_C   = HW'(H_START + H_VISIBLE);
    localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_START_C = VW'(V_START);
    localparam logic [VW-1:0] V_END_C   = VW'(V_START + V_VISIBLE);

    generate
        if (CLK_DIV < 2 || H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_param_err
            $error("vga_timing_gen: CLK_DIV must be >= 2 and every width non-zero");
        end
    endgenerate

    function automatic logic in_window(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return (h >= H_START_C) && (h < H_END_C) && (v >= V_START_C) && (v < V_END_C);
    endfunction

    logic          adv_s;
    logic          pix_en_s;
    logic          vga_clk_s;
    logic [HW-1:0] h_cnt_r, h_next_s, pos_h_s;
    logic [VW-1:0] v_cnt_r, v_next_s, pos_v_s;
    logic          h_wrap_s, v_wrap_s;
    logic          vis_now_s, vis_pos_s;
    logic [XW-1:0] x_next_s;
    logic [YW-1:0] y_next_s;
    logic          hsync_r, vsync_r, display_r, blank_n_r;
    logic          line_start_r, frame_start_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;

    pix_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk50),
        .rst_n   (rst_n),
        .adv     (adv_s),
        .pix_en  (pix_en_s),
        .vga_clk (vga_clk_s)
    );

    // Raster counter next-state: step on a pixel advance, wrap line then frame.
    always_comb begin
        h_next_s = h_cnt_r;
        v_next_s = v_cnt_r;
        h_wrap_s = 1'b0;
        v_wrap_s = 1'b0;
        if (adv_s) begin
            if (h_cnt_r == H_LAST_C) begin
                h_next_s = '0;
                h_wrap_s = 1'b1;
                if (v_cnt_r == V_LAST_C) begin
                    v_next_s = '0;
                    v_wrap_s = 1'b1;
                end else begin
                    v_next_s = v_cnt_r + VW'(1);
                end
            end else begin
                h_next_s = h_cnt_r + HW'(1);
            end
        end else begin
            h_next_s = h_cnt_r;
        end
    end

    // Position that coordinates describe: the current pixel, or the one after it.
    always_comb begin
        pos_h_s = h_next_s;
        pos_v_s = v_next_s;
`ifdef VGA_TIMING_LEAD_EN
        if (h_next_s == H_LAST_C) begin
            pos_h_s = '0;
            if (v_next_s == V_LAST_C) begin
                pos_v_s = '0;
            end else begin
                pos_v_s = v_next_s + VW'(1);
            end
        end else begin
            pos_h_s = h_next_s + HW'(1);
        end
`endif
    end

    // Visibility and visible-relative coordinates, zero outside the window.
    always_comb begin
        vis_now_s = in_window(h_next_s, v_next_s);
        vis_pos_s = in_window(pos_h_s, pos_v_s);
        x_next_s  = '0;
        y_next_s  = '0;
        if (vis_pos_s) begin
            x_next_s = XW'(pos_h_s - H_START_C);
            y_next_s = YW'(pos_v_s - V_START_C);
        end else begin
            x_next_s = '0;
            y_next_s = '0;
        end
    end

    // Counter state and every raster output, updated on the same edge.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            h_cnt_r       <= H_LAST_C;
            v_cnt_r       <= V_LAST_C;
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            display_r     <= 1'b0;
            blank_n_r     <= 1'b0;
            x_r           <= '0;
            y_r           <= '0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            h_cnt_r       <= h_next_s;
            v_cnt_r       <= v_next_s;
            hsync_r       <= (h_next_s < H_SYNC_C) ? HS_POL : ~HS_POL;
            vsync_r       <= (v_next_s < V_SYNC_C) ? VS_POL : ~VS_POL;
            display_r     <= vis_pos_s;
            blank_n_r     <= vis_now_s;
            x_r           <= x_next_s;
            y_r           <= y_next_s;
            line_start_r  <= h_wrap_s;
            frame_start_r <= v_wrap_s;
        end
    end

    assign vga.hsync        = hsync_r;
    assign vga.vsync        = vsync_r;
    assign vga.display_area = display_r;
    assign vga.x            = x_r;
    assign vga.y            = y_r;
    assign vga.pix_en       = pix_en_s;
    assign vga.line_start   = line_start_r;
    assign vga.frame_start  = frame_start_r;
    assign vga.vga_blank_n  = blank_n_r;
    assign vga.vga_sync_n   = 1'b0;
    assign vga.vga_clk      = vga_clk_s;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with three instances sharing clock and reset:
//   a: defaults (640x480, CLK_DIV=2)
//   b: CLK_DIV=4, 320x240, HS_POL=1, vertical back porch shortened to 3
//      so a visible line is reached quickly
//   c: tiny raster (H 3/2/8/2 = 15, V 2/2/4/1 = 9, HS_POL=1) for
//      whole-frame and table-driven checks
module tb_vga_timing_gen;
    logic clk50 = 1'b0;
    logic rst_n;
    always #10 clk50 = ~clk50;

`ifdef VGA_TIMING_LEAD_EN
    localparam bit LEAD = 1'b1;
`else
    localparam bit LEAD = 1'b0;
`endif

    vga_timing_if #(.XW(10), .YW(9)) va ();
    vga_timing_if #(.XW(9),  .YW(8)) vb ();
    vga_timing_if #(.XW(3),  .YW(2)) vc ();

    vga_timing_gen u_a (.clk50(clk50), .rst_n(rst_n), .vga(va.master));
    vga_timing_gen #(.CLK_DIV(4), .H_VISIBLE(320), .V_VISIBLE(240), .V_BACK(3),
                     .HS_POL(1'b1)) u_b (.clk50(clk50), .rst_n(rst_n), .vga(vb.master));
    vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                     .HS_POL(1'b1), .VS_POL(1'b0)) u_c (.clk50(clk50), .rst_n(rst_n), .vga(vc.master));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sample point: just after the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk50);
        #1;
    endtask

    // Position trackers rebuilt from the strobes.
    int ha = -1000;
    int vb_line = -1000;
    int pc = -1000;
    always @(negedge clk50) begin
        if (va.line_start) ha <= 0; else if (va.pix_en) ha <= ha + 1;
        if (vb.frame_start) vb_line <= 0; else if (vb.line_start) vb_line <= vb_line + 1;
        if (vc.frame_start) pc <= 0; else if (vc.pix_en) pc <= pc + 1;
    end

    typedef struct {
        int h; int v;
        int hs; int vs; int ls;
        int d; int x; int y;
        int ld; int lx; int ly;
    } vec_t;
    vec_t vecs[12];

    int n, na, nb, nc, fs_a, ls_a, hs_a, vs_a, fs_b, fs_c, hs_c;
    int guard, cnt, c1, c2, c3, c4, c5, xmax, xfirst, stray;

    initial begin
        //           h   v  hs vs ls  d  x  y  ld lx ly
        vecs[0]  = '{0,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{2,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{3,  2, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{14, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{4,  4, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        vecs[5]  = '{5,  4, 0, 1, 0, 1, 0, 0, 1, 1, 0};
        vecs[6]  = '{9,  5, 0, 1, 0, 1, 4, 1, 1, 5, 1};
        vecs[7]  = '{12, 7, 0, 1, 0, 1, 7, 3, 0, 0, 0};
        vecs[8]  = '{13, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{14, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{12, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{14, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        rst_n = 1'b0;
        repeat (4) tick();
        check("a_rst_hsync", va.hsync, 1);
        check("a_rst_vsync", va.vsync, 1);
        check("a_rst_display", va.display_area, 0);
        check("a_rst_x", va.x, 0);
        check("a_rst_y", va.y, 0);
        check("a_rst_pix_en", va.pix_en, 0);
        check("a_rst_line_start", va.line_start, 0);
        check("a_rst_frame_start", va.frame_start, 0);
        check("a_rst_vga_clk", va.vga_clk, 0);
        check("a_rst_blank_n", va.vga_blank_n, 0);
        check("a_sync_n", va.vga_sync_n, 0);
        check("b_rst_hsync", vb.hsync, 0);
        check("c_rst_hsync", vc.hsync, 0);
        check("c_rst_vsync", vc.vsync, 1);

        // Release: first pix_en and frame_start land in cycle CLK_DIV
        rst_n = 1'b1;
        n = 1; na = 0; nb = 0; nc = 0;
        fs_a = 0; ls_a = 0; hs_a = 1; vs_a = 1; fs_b = 0; fs_c = 0; hs_c = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (va.pix_en && na == 0) begin
                na = n; fs_a = va.frame_start; ls_a = va.line_start; hs_a = va.hsync; vs_a = va.vsync;
            end
            if (vb.pix_en && nb == 0) begin
                nb = n; fs_b = vb.frame_start;
            end
            if (vc.pix_en && nc == 0) begin
                nc = n; fs_c = vc.frame_start; hs_c = vc.hsync;
            end
        end
        check("a_first_pix_cycle", na, 2);
        check("a_first_frame_start", fs_a, 1);
        check("a_first_line_start", ls_a, 1);
        check("a_first_hsync", hs_a, 0);
        check("a_first_vsync", vs_a, 0);
        check("b_first_pix_cycle", nb, 4);
        check("b_first_frame_start", fs_b, 1);
        check("c_first_pix_cycle", nc, 2);
        check("c_first_frame_start", fs_c, 1);
        check("c_first_hsync", hs_c, 1);

        // Table-driven vectors over one full frame of the tiny raster
        guard = 0;
        do begin tick(); guard++; end while (!vc.frame_start && guard < 1000);
        check("c_frame_wait", vc.frame_start, 1);
        foreach (vecs[i]) begin
            guard = 0;
            while (!(vc.pix_en && pc == vecs[i].v * 15 + vecs[i].h) && guard < 1000) begin
                tick(); guard++;
            end
            check($sformatf("c_vec%0d_reached", i), int'(guard < 1000), 1);
            check($sformatf("c_vec%0d_hsync", i), vc.hsync, vecs[i].hs);
            check($sformatf("c_vec%0d_vsync", i), vc.vsync, vecs[i].vs);
            check($sformatf("c_vec%0d_line_start", i), vc.line_start, vecs[i].ls);
            check($sformatf("c_vec%0d_blank_n", i), vc.vga_blank_n, vecs[i].d);
            check($sformatf("c_vec%0d_display", i), vc.display_area, LEAD ? vecs[i].ld : vecs[i].d);
            check($sformatf("c_vec%0d_x", i), vc.x, LEAD ? vecs[i].lx : vecs[i].x);
            check($sformatf("c_vec%0d_y", i), vc.y, LEAD ? vecs[i].ly : vecs[i].y);
        end

        // Tiny raster: frame period, vsync width, hsync width, lines per frame
        guard = 0;
        do begin tick(); guard++; end while (!vc.frame_start && guard < 1000);
        check("c_frame_wait2", vc.frame_start, 1);
        cnt = 0; c1 = 0; c2 = 0; c3 = 0;
        do begin
            if (vc.vsync == 1'b0) c1++;
            if (vc.hsync == 1'b1) c2++;
            if (vc.line_start) c3++;
            tick(); cnt++;
        end while (!vc.frame_start && cnt < 1000);
        check("c_frame_period", cnt, 270);
        check("c_vsync_low_cycles", c1, 60);
        check("c_hsync_high_cycles", c2, 54);
        check("c_lines_per_frame", c3, 9);

        // Defaults: one line of an early, non-visible row
        guard = 0;
        do begin tick(); guard++; end while (!va.line_start && guard < 2000);
        check("a_line_wait", va.line_start, 1);
        cnt = 0; c1 = 0; c2 = 0; c3 = 0; c4 = 0;
        do begin
            if (va.hsync == 1'b0) c1++;
            if (va.display_area) c2++;
            if (va.vga_clk != va.pix_en) c3++;
            if (va.x != 0 || va.y != 0) c4++;
            tick(); cnt++;
        end while (!va.line_start && cnt < 4000);
        check("a_line_period", cnt, 1600);
        check("a_hsync_low_cycles", c1, 192);
        check("a_display_cycles_blank_row", c2, 0);
        check("a_vga_clk_vs_pix_en", c3, 0);
        check("a_xy_nonzero_outside", c4, 0);

        // CLK_DIV=4, 320 wide, HS_POL=1: one visible line (row y=1)
        guard = 0;
        while (!(vb.line_start && vb_line == 6) && guard < 25000) begin tick(); guard++; end
        check("b_line_wait", int'(guard < 25000), 1);
        cnt = 0; c1 = 0; c2 = 0; c3 = 0; c4 = 0; c5 = 0; xmax = 0; xfirst = -1;
        do begin
            if (vb.hsync == 1'b1) c1++;
            if (vb.display_area) begin
                c2++;
                if (xfirst < 0) xfirst = vb.x;
                if (int'(vb.x) > xmax) xmax = vb.x;
                if (vb.y != 8'd1) c4++;
            end
            if (vb.vga_clk) c3++;
            if (vb.vga_blank_n) c5++;
            tick(); cnt++;
        end while (!vb.line_start && cnt < 4000);
        check("b_line_period", cnt, 1920);
        check("b_hsync_high_cycles", c1, 384);
        check("b_display_cycles", c2, 1280);
        check("b_blank_n_cycles", c5, 1280);
        check("b_vga_clk_high_cycles", c3, 960);
        check("b_x_first", xfirst, 0);
        check("b_x_max", xmax, 319);
        check("b_y_row", c4, 0);

        // Mid-line reset on the defaults instance at h_cnt=500
        guard = 0;
        while (!(va.pix_en && ha == 500) && guard < 4000) begin tick(); guard++; end
        check("a_h500_wait", int'(guard < 4000), 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("a_mid_rst_pix_en", va.pix_en, 0);
        check("a_mid_rst_vga_clk", va.vga_clk, 0);
        check("a_mid_rst_hsync", va.hsync, 1);
        check("a_mid_rst_vsync", va.vsync, 1);
        check("a_mid_rst_display", va.display_area, 0);
        check("a_mid_rst_line_start", va.line_start, 0);
        check("c_mid_rst_hsync", vc.hsync, 0);
        tick();
        tick();
        rst_n = 1'b1;
        n = 1; na = 0; fs_a = 0; stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (va.line_start && !va.frame_start) stray++;
            if (va.pix_en && na == 0) begin
                na = n; fs_a = va.frame_start;
            end
        end
        check("a_rerelease_pix_cycle", na, 2);
        check("a_rerelease_frame_start", fs_a, 1);
        check("a_rerelease_stray_line_start", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Replaces the fixed 640x480 sync block.
- Runs on the 50 MHz system clock with a programmable pixel-enable divider.
- All porch, sync and visible widths and the sync polarities are parameters.
- Adds a synchronous reset, start-of-line and start-of-frame strobes, and visible-relative pixel coordinates.
- Feeds the game renderer and the DAC pins (hsync, vsync, blank, sync, clk).

Parameters:
- CLK_DIV, 2: clk50 cycles per pixel; legal values are 2 and above.
- H_VISIBLE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- HS_POL, 0: hsync level while the pulse is asserted.
- VS_POL, 0: vsync level while the pulse is asserted.

Ports:
- clk50  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- hsync  out  1  horizontal sync, registered.
- vsync  out  1  vertical sync, registered.
- display_area  out  1  high while the current pixel is visible.
- x  out  XW=$clog2(H_VISIBLE)  visible column, 0..H_VISIBLE-1.
- y  out  YW=$clog2(V_VISIBLE)  visible row, 0..V_VISIBLE-1.
- pix_en  out  1  one-clk50 strobe on each pixel advance.
- line_start  out  1  one-clk50 strobe when h_cnt wraps to 0.
- frame_start  out  1  one-clk50 strobe when h_cnt and v_cnt both wrap to 0.
- vga_blank_n  out  1  equals display_area.
- vga_sync_n  out  1  constant 0.
- vga_clk  out  1  divided pixel clock for the DAC.

Behaviour:
- Derived values:
  - H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT (default 800).
  - V_TOTAL = V_SYNC+V_BACK+V_VISIBLE+V_FRONT (default 525).
  - H_START = H_SYNC+H_BACK (default 144).
  - V_START = V_SYNC+V_BACK (default 35).
  - Each line and frame runs in the order sync, back porch, visible, front porch.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 exactly in the cycle where div_cnt==CLK_DIV-1.
  - vga_clk is registered and equals (div_cnt >= CLK_DIV/2).
- Counters:
  - On a cycle with pix_en, h_cnt increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
  - Counters hold when pix_en=0.
- Output timing: every output is registered from the next counter values, so outputs change on the same clk50 edge as the counters and stay consistent with them.
- Sync levels:
  - hsync = HS_POL when h_cnt<H_SYNC, otherwise ~HS_POL.
  - vsync = VS_POL when v_cnt<V_SYNC, otherwise ~VS_POL.
- display_area = (H_START <= h_cnt < H_START+H_VISIBLE) && (V_START <= v_cnt < V_START+V_VISIBLE).
- Coordinates:
  - x = h_cnt-H_START and y = v_cnt-V_START while display_area=1.
  - x and y are forced to 0 when display_area=0.
  - Arithmetic is unsigned and truncated to XW/YW bits. No overflow is possible inside the visible window.
- Strobes:
  - line_start and frame_start are high for exactly one clk50 cycle.
  - They assert coincident with the pix_en edge that moves the counters to h_cnt=0, and to (0,0) respectively.
  - frame_start implies line_start.
- Reset values (while rst_n=0):
  - div_cnt=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1.
  - hsync=~HS_POL, vsync=~VS_POL.
  - display_area, x, y, pix_en, line_start, frame_start and vga_clk are all 0.
- After reset:
  - The first pix_en comes CLK_DIV cycles after release.
  - That edge wraps to (0,0) and fires frame_start, so every frame begins with a full strobe.
- Reset mid-frame: immediate on the next clk50 edge. No partial strobes are emitted. Timing restarts as above.
- Elaboration check: illegal parameters (CLK_DIV<2, any zero width) are reported with $error at elaboration.

Optional Feature:
- Macro: VGA_TIMING_LEAD_EN.
- Defined:
  - x, y and display_area describe the next pixel, computed from h_cnt+1 with line and frame wrap applied.
  - They therefore lead hsync/vsync/vga_blank_n by one pixel period, letting a 1-cycle-latency sprite ROM align.
  - vga_blank_n still uses the un-led display_area.
- Undefined: all outputs are aligned, as described in Behaviour.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants (H_*/V_* values);
  - the HS_POL/VS_POL defaults;
  - functions h_total/v_total.
- One sub-module, pix_clk_div, holds:
  - div_cnt;
  - the pix_en and vga_clk outputs;
  - the CLK_DIV parameter.

Test Plan:
1. Reset, then release rst_n -> first pix_en and frame_start in the same cycle, 2 clk50 cycles after release. hsync=0 and vsync=0 on that edge.
2. Defaults, run 2 frames -> frame_start period is 840000 clk50 cycles and line_start period is 1600. hsync low for 192 clk50 cycles per line; vsync low for 2 lines.
3. Defaults, probe a line -> display_area rises at h_cnt=144 with x=0 and falls after x=639 at h_cnt=784. y runs 0..479 over v_cnt 35..514; x=y=0 outside the visible window.
4. CLK_DIV=4, H_VISIBLE=320, V_VISIBLE=240, HS_POL=1 -> line is 480 pixels = 1920 clk50 cycles. hsync is high for 96 pixels; x max is 319.
5. Assert rst_n=0 mid-line at h_cnt=500 for 3 cycles -> outputs at reset values next edge. Release gives frame_start after 2 cycles; no stray line_start is seen.
6. With VGA_TIMING_LEAD_EN -> x=0 and display_area=1 at h_cnt=143, while vga_blank_n rises at h_cnt=144. At h_cnt=799 of the last line, x/y report (0,0) only if (0,0) is visible; otherwise 0 with display_area=0.
